// File: rtl/fd_pipe_exc.sv
// F/D pipeline register for the exception-capable pipeline.
// After a faulting fetch reaches D, younger fetches become bubbles until the exception flush arrives.
module fd_pipe_exc #(
  parameter logic [31:0] RESET_PC8 = 32'h0000_3008,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrF,
  input  logic [31:0] pc8F,
  input  logic [31:0] causeF,
  input  logic        stall,
  input  logic        excflush,
  output logic [31:0] instrD,
  output logic [31:0] pc8D,
  output logic [31:0] causeD,
  output logic        validD,
  output logic        excD,
  output logic        pendD
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_instr;
  logic [31:0] r_pc8;
  logic [31:0] r_cause;
  logic        r_valid;
  logic        r_exc;
  logic        w_fault;

  assign w_fault = (causeF[6:2] != 5'd0);

  // Priority is reset > excflush > stall > capture. A faulting fetch keeps validD
  // so M still sees the ExcCode and BD, but its instruction word is never decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_instr <= NOP_INSTR;
      r_pc8   <= RESET_PC8;
      r_cause <= 32'd0;
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
    end else if (excflush) begin
      r_state <= RUN;
      r_instr <= NOP_INSTR;
      r_pc8   <= pc8F;
      r_cause <= 32'd0;
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
    end else if (!stall) begin
      r_pc8 <= pc8F;
      if (r_state == RUN) begin
        r_instr <= w_fault ? NOP_INSTR : instrF;
        r_cause <= causeF;
        r_valid <= 1'b1;
        r_exc   <= w_fault;
        if (w_fault) begin
          r_state <= PEND;
        end
      end else begin
        r_instr <= NOP_INSTR;
        r_cause <= 32'd0;
        r_valid <= 1'b0;
        r_exc   <= 1'b0;
      end
    end
  end

  assign instrD = r_instr;
  assign pc8D   = r_pc8;
  assign causeD = r_cause;
  assign validD = r_valid;
  assign excD   = r_exc;
  assign pendD  = (r_state == PEND);

endmodule

// File: tb/tb_fd_pipe_exc.sv
// Directed self-checking bench for fd_pipe_exc using hand-computed expected values.
module tb_fd_pipe_exc;

  logic        clk;
  logic        reset;
  logic [31:0] instrF;
  logic [31:0] pc8F;
  logic [31:0] causeF;
  logic        stall;
  logic        excflush;
  logic [31:0] instrD;
  logic [31:0] pc8D;
  logic [31:0] causeD;
  logic        validD;
  logic        excD;
  logic        pendD;

  int totalChecks = 0;
  int badChecks   = 0;

  fd_pipe_exc dut (
    .clk      (clk),
    .reset    (reset),
    .instrF   (instrF),
    .pc8F     (pc8F),
    .causeF   (causeF),
    .stall    (stall),
    .excflush (excflush),
    .instrD   (instrD),
    .pc8D     (pc8D),
    .causeD   (causeD),
    .validD   (validD),
    .excD     (excD),
    .pendD    (pendD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr, input logic [31:0] pc8,
                               input logic [31:0] cause, input logic stl, input logic flush);
    reset    = rst;
    instrF   = instr;
    pc8F     = pc8;
    causeF   = cause;
    stall    = stl;
    excflush = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] eInstr, input logic [31:0] ePc8,
                          input logic [31:0] eCause, input logic eValid, input logic eExc, input logic ePend);
    checkOutput({tag, ".instrD"}, instrD, eInstr);
    checkOutput({tag, ".pc8D"},   pc8D,   ePc8);
    checkOutput({tag, ".causeD"}, causeD, eCause);
    checkOutput({tag, ".validD"}, {31'd0, validD}, {31'd0, eValid});
    checkOutput({tag, ".excD"},   {31'd0, excD},   {31'd0, eExc});
    checkOutput({tag, ".pendD"},  {31'd0, pendD},  {31'd0, ePend});
  endtask

  initial begin
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0010, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0010, 1'b0, 1'b0);
    checkAll("reset", 32'h0, 32'h3008, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'h3C01_1234, 32'h3008, 32'h0, 1'b0, 1'b0);
    checkAll("t1.capture", 32'h3C01_1234, 32'h3008, 32'h0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'h8C22_0000, 32'h3016, 32'h8000_0010, 1'b0, 1'b0);
    checkAll("t2.fault", 32'h0, 32'h3016, 32'h8000_0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h2402_0001, 32'h301C, 32'h0, 1'b0, 1'b0);
    checkAll("t2.bubble1", 32'h0, 32'h301C, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h2403_0002, 32'h3020, 32'h8000_0000, 1'b0, 1'b0);
    checkAll("t2.bubble2", 32'h0, 32'h3020, 32'h0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 32'h2404_0003, 32'h3024, 32'h0, 1'b1, 1'b1);
    checkAll("t3.flush", 32'h0, 32'h3024, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0043_0820, 32'h3028, 32'h0, 1'b0, 1'b0);
    checkAll("t3.resume", 32'h0043_0820, 32'h3028, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'hA000_0000 + 32'(i), 32'h3030 + 32'(4 * i), 32'h0000_0010, 1'b1, 1'b0);
      checkAll("t4.stall", 32'h0043_0820, 32'h3028, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 32'hAC01_0000, 32'h3038, 32'h8000_0000, 1'b0, 1'b0);
    checkAll("t4.release", 32'hAC01_0000, 32'h3038, 32'h8000_0000, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'h1111_1111, 32'h303C, 32'h0000_0010, 1'b0, 1'b0);
    checkAll("t5.fault", 32'h0, 32'h303C, 32'h0000_0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h2222_2222, 32'h3040, 32'h0, 1'b1, 1'b0);
    checkAll("t5.pendstall", 32'h0, 32'h303C, 32'h0000_0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h3333_3333, 32'h3044, 32'h0000_0010, 1'b1, 1'b0);
    checkAll("t5.reset", 32'h0, 32'h3008, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'h4444_4444, 32'h3048, 32'h0000_0010, 1'b0, 1'b0);
    checkAll("t6.fault1", 32'h0, 32'h3048, 32'h0000_0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h5555_5555, 32'h304C, 32'h8000_0010, 1'b0, 1'b0);
    checkAll("t6.fault2", 32'h0, 32'h304C, 32'h0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 32'h6666_6666, 32'h3050, 32'h0, 1'b0, 1'b1);
    checkAll("t6.flush", 32'h0, 32'h3050, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
